stream_packer: RTL and testbench
================================

Name: stream_packer

Overview:
- Downstream neighbour of the skid buffer: takes a narrow valid/ready stream with a last marker and packs RATIO consecutive beats into one wide output word.
- Partial words are flushed on last and carry a per-lane keep mask.
- Sustains one input beat per clock under continuous output ready.
- Typical placement: after a narrow-side skid_buffer, ahead of a wide bus master or FIFO.

Parameters:
- IN_WIDTH, 8, width of one input beat in bits; must be >= 1.
- RATIO, 4, input beats per output word; must be >= 2.
- OUT_WIDTH = IN_WIDTH*RATIO is derived, not overridable.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- in_data  input  IN_WIDTH  Input beat payload.
- in_last  input  1  Marks the final beat of a packet.
- in_valid  input  1  Input beat present.
- in_ready  output  1  Packer accepts a beat this cycle.
- out_data  output  IN_WIDTH*RATIO  Packed word; lane 0 occupies the LSBs.
- out_keep  output  RATIO  Per-lane valid mask; bit i covers lane i.
- out_last  output  1  Word contains the packet's final beat.
- out_valid  output  1  Packed word present.
- out_ready  input  1  Downstream accepts the word.

Behaviour:
- Reset, sampled on a clk edge: out_valid=0, out_data=0, out_keep=0, out_last=0, lane counter=0. in_ready reads 1 on the first cycle after reset.
- Reset mid-packet discards the partial word and any held word without emitting it.
- Handshakes:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready only, never from in_valid).
  - Outputs are registered; out_data, out_keep and out_last are stable while out_valid && !out_ready.
- States, encoded by out_valid plus lane counter L in 0..RATIO-1:
  - FILL: out_valid=0; accumulating lanes 0..L-1.
  - HOLD: out_valid=1; complete word waiting for the consumer.
- Accepted beat at lane L:
  - Writes in_data to lane L and sets keep[L].
  - If L==RATIO-1 or in_last=1: next cycle out_valid=1, out_last=in_last, L returns to 0.
  - Otherwise L increments.
- Latency: the word is presented on out_valid one cycle after its completing beat is accepted.
- Simultaneous output transfer and input transfer in HOLD: the held word leaves, and the new beat writes lane 0. All other lanes' data and keep are cleared in the same edge, so no stale bits carry over. This gives full throughput with no bubble.
- HOLD with out_ready=0: in_ready=0; no input accepted.
- Output transfer with no input transfer: out_valid=0, keep cleared to 0, data cleared to 0.
- Partial word (in_last before lane RATIO-1):
  - Keep is contiguous from lane 0.
  - Unused lanes of out_data are 0.
- in_last on lane RATIO-1: full word with out_last=1 and keep all ones.
- Counter wraps only through completion; no overflow path exists.
- Input behaviour with in_valid=0 is ignored; in_data/in_last are don't-care.

Test Plan:
- Continuous stream, out_ready=1, beats 0x11,0x22,0x33,0x44,0x55..0x88 with last on 0x88 -> out_data 0x44332211 keep 0xF last 0, then 0x88776655 keep 0xF last 1. in_ready is held at 1 throughout, giving 8 beats in 8 cycles.
- Short packet 0xA1,0xB2 with last on 0xB2 -> out_data 0x0000B2A1 keep 0x3 last 1. The next packet starts at lane 0.
- Backpressure: out_ready=0 for 5 cycles after a word completes -> out_valid=1 and data stable. in_ready=0; no beat is lost. When out_ready=1, the word drains and the pending input beat is accepted in the same cycle.
- Single-beat packet 0x5C with last -> 0x0000005C keep 0x1 last 1. The following full packet shows no stale lanes.
- Reset asserted after 2 beats of a 4-beat word -> all outputs 0 next cycle. A fresh packet 0x01..0x04 yields 0x04030201 keep 0xF.
- Random in_valid/out_ready toggling over 10k beats, compared against a reference model -> identical packed words, keep, last, order; no duplication or drops.

Source files
------------

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs RATIO narrow stream beats into one wide word with keep mask
// Partial words are flushed on in_last; unused lanes read as zero.
module stream_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = $clog2(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LANE_W-1:0]     lane_q,  lane_d;
    logic [OUT_WIDTH-1:0]  data_q,  data_d;
    logic [RATIO-1:0]      keep_q,  keep_d;
    logic                  last_q,  last_d;

    logic                  in_fire;
    logic                  out_fire;

    // Ready depends only on our own state and the consumer, never on in_valid.
    assign in_ready  = (state_q == ST_FILL) || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = (state_q == ST_HOLD) && out_ready;

    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;

        // Draining first clears the word so a beat landing in the same
        // edge starts a clean lane 0 with no stale lanes behind it.
        if (out_fire) begin
            state_d = ST_FILL;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
        end

        if (in_fire) begin
            data_d[lane_q*IN_WIDTH +: IN_WIDTH] = in_data;
            keep_d[lane_q]                      = 1'b1;
            if ((lane_q == LAST_LANE) || in_last) begin
                state_d = ST_HOLD;
                last_d  = in_last;
                lane_d  = '0;
            end else begin
                lane_d  = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
            lane_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - vector table, reset sequences and random model check for stream_packer
module tb_stream_packer;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;

    logic              clk = 1'b0;
    logic              reset;
    logic [IN_W-1:0]   in_data;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic [RATIO-1:0]  out_keep;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    stream_packer #(.IN_WIDTH(IN_W), .RATIO(RATIO)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  d;
        logic             l;
        logic             v;
        logic             r;
        logic             e_ir;
        logic             e_ov;
        logic [OUT_W-1:0] e_d;
        logic [RATIO-1:0] e_k;
        logic             e_l;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [RATIO-1:0] k;
        logic             l;
    } word_t;

    vec_t  vecs[$];
    word_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [IN_W-1:0] d, input logic l, input logic v, input logic r,
                       input logic e_ir, input logic e_ov, input logic [OUT_W-1:0] e_d,
                       input logic [RATIO-1:0] e_k, input logic e_l);
        vec_t t;
        t.d = d; t.l = l; t.v = v; t.r = r;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_d = e_d; t.e_k = e_k; t.e_l = e_l;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [IN_W-1:0] d, input logic l, input logic v, input logic r);
        in_data = d; in_last = l; in_valid = v; out_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        @(negedge clk);
        chk({name, "_ov"},   64'(out_valid), 64'd0);
        chk({name, "_data"}, 64'(out_data),  64'd0);
        chk({name, "_keep"}, 64'(out_keep),  64'd0);
        chk({name, "_last"}, 64'(out_last),  64'd0);
        chk({name, "_ir"},   64'(in_ready),  64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();
        chk_idle("reset_state");

        // Continuous stream, short packet, single beat, backpressure.
        add(8'h11,0,1,1, 1,0,'0,'0,0);
        add(8'h22,0,1,1, 1,0,'0,'0,0);
        add(8'h33,0,1,1, 1,0,'0,'0,0);
        add(8'h44,0,1,1, 1,0,'0,'0,0);
        add(8'h55,0,1,1, 1,1,32'h44332211,4'hF,0);
        add(8'h66,0,1,1, 1,0,'0,'0,0);
        add(8'h77,0,1,1, 1,0,'0,'0,0);
        add(8'h88,1,1,1, 1,0,'0,'0,0);
        add(8'h00,0,0,1, 1,1,32'h88776655,4'hF,1);
        add(8'h00,0,0,1, 1,0,'0,'0,0);
        add(8'hA1,0,1,1, 1,0,'0,'0,0);
        add(8'hB2,1,1,1, 1,0,'0,'0,0);
        add(8'h00,0,0,1, 1,1,32'h0000B2A1,4'h3,1);
        add(8'h00,0,0,1, 1,0,'0,'0,0);
        add(8'h5C,1,1,1, 1,0,'0,'0,0);
        add(8'h01,0,1,1, 1,1,32'h0000005C,4'h1,1);
        add(8'h02,0,1,1, 1,0,'0,'0,0);
        add(8'h03,0,1,1, 1,0,'0,'0,0);
        add(8'h04,1,1,1, 1,0,'0,'0,0);
        add(8'h00,0,0,1, 1,1,32'h04030201,4'hF,1);
        add(8'h00,0,0,1, 1,0,'0,'0,0);
        add(8'hA0,0,1,0, 1,0,'0,'0,0);
        add(8'hA1,0,1,0, 1,0,'0,'0,0);
        add(8'hA2,0,1,0, 1,0,'0,'0,0);
        add(8'hA3,0,1,0, 1,0,'0,'0,0);
        for (int i = 0; i < 5; i++)
            add(8'hB0,1,1,0, 0,1,32'hA3A2A1A0,4'hF,0);
        add(8'hB0,1,1,1, 1,1,32'hA3A2A1A0,4'hF,0);
        add(8'h00,0,0,1, 1,1,32'h000000B0,4'h1,1);
        add(8'h00,0,0,1, 1,0,'0,'0,0);

        foreach (vecs[i]) begin
            in_data = vecs[i].d; in_last = vecs[i].l;
            in_valid = vecs[i].v; out_ready = vecs[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_ir", i), 64'(in_ready),  64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].e_d));
                chk($sformatf("vec%0d_keep", i), 64'(out_keep), 64'(vecs[i].e_k));
                chk($sformatf("vec%0d_last", i), 64'(out_last), 64'(vecs[i].e_l));
            end
            @(posedge clk); #1;
        end

        // Reset after two beats discards the partial word.
        drive(8'h01,0,1,1);
        drive(8'h02,0,1,1);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("reset_mid");
        drive(8'h01,0,1,1);
        drive(8'h02,0,1,1);
        drive(8'h03,0,1,1);
        drive(8'h04,0,1,1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_reset_ov",   64'(out_valid), 64'd1);
        chk("after_reset_data", 64'(out_data),  64'h04030201);
        chk("after_reset_keep", 64'(out_keep),  64'hF);
        chk("after_reset_last", 64'(out_last),  64'd0);
        @(posedge clk); #1;

        // Reset while a word is held discards it.
        drive(8'hC0,0,1,0);
        drive(8'hC1,0,1,0);
        drive(8'hC2,1,1,0);
        @(negedge clk);
        chk("held_ov", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("reset_hold");

        // Randomized traffic against a packet-level reference model.
        begin
            int               beats = 0;
            int               cyc = 0;
            int               cnt = 0;
            logic [OUT_W-1:0] cur_d = '0;
            logic [RATIO-1:0] cur_k = '0;
            logic             was_held = 1'b0;
            logic [OUT_W-1:0] held_d = '0;
            logic [RATIO-1:0] held_k = '0;
            logic             held_l = 1'b0;
            int               words = 0;
            word_t            w;

            while (beats < 10000 && cyc < 60000) begin
                in_valid  = ($urandom_range(0, 99) < 70);
                in_data   = IN_W'($urandom);
                in_last   = ($urandom_range(0, 4) == 0);
                out_ready = ($urandom_range(0, 99) < 70);
                @(negedge clk);
                cyc++;
                if (in_ready !== (!out_valid || out_ready))
                    chk("rand_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                if (was_held) begin
                    chk("rand_hold_valid", 64'(out_valid), 64'd1);
                    if ({out_data, out_keep, out_last} !== {held_d, held_k, held_l})
                        chk("rand_hold_stable", 64'(out_data), 64'(held_d));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_extra_word", 64'(out_data), 64'hDEAD);
                    end else begin
                        w = exp_q.pop_front();
                        chk($sformatf("rand_word%0d", words),
                            {28'd0, out_data, out_keep, out_last}, {28'd0, w.d, w.k, w.l});
                        words++;
                    end
                end
                was_held = out_valid && !out_ready;
                held_d = out_data; held_k = out_keep; held_l = out_last;
                if (in_valid && in_ready) begin
                    cur_d = cur_d | (OUT_W'(in_data) << (IN_W * cnt));
                    cur_k = cur_k | (RATIO'(1) << cnt);
                    cnt++;
                    beats++;
                    if (cnt == RATIO || in_last) begin
                        w.d = cur_d; w.k = cur_k; w.l = in_last;
                        exp_q.push_back(w);
                        cur_d = '0; cur_k = '0; cnt = 0;
                    end
                end
                @(posedge clk); #1;
            end
            chk("rand_beat_budget", 64'(beats >= 10000), 64'd1);

            in_valid = 1'b0; out_ready = 1'b1;
            for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
                @(negedge clk);
                if (out_valid) begin
                    w = exp_q.pop_front();
                    chk($sformatf("drain_word%0d", words),
                        {28'd0, out_data, out_keep, out_last}, {28'd0, w.d, w.k, w.l});
                    words++;
                end
                @(posedge clk); #1;
            end
            chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            chk("rand_end_idle", 64'(out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
